// File: rtl/memoredf_pkg.sv
// Shared packet layout, response codes and FSM encoding for the MemorEDF front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package memoredf_pkg;

   localparam int ID_W      = 32;
   localparam int ADDR_W    = 40;
   localparam int DATA_W    = 128;
   localparam int STRB_W    = DATA_W / 8;
   localparam int MAX_BEATS = 4;

   localparam int META_W    = ADDR_W + ID_W + 29;
   localparam int DATA_SLOTS_W = MAX_BEATS * DATA_W;
   localparam int STRB_SLOTS_W = MAX_BEATS * STRB_W;
   localparam int PKT_W     = 1 + META_W + STRB_SLOTS_W + DATA_SLOTS_W;

   // Field offsets inside the flat packet; beat 0 always sits in the most significant slot.
   localparam int DATA_LSB  = 0;
   localparam int STRB_LSB  = DATA_LSB + DATA_SLOTS_W;
   localparam int META_LSB  = STRB_LSB + STRB_SLOTS_W;
   localparam int TYPE_BIT  = META_LSB + META_W;

   localparam logic TYPE_WRITE = 1'b1;
   localparam logic TYPE_READ  = 1'b0;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WDATA,
      ST_PKT_OUT,
      ST_BRESP
   } pkt_state_e;

   // Address-channel metadata in packet order (MSB first).
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [ID_W-1:0]   id;
      logic [7:0]        len;
      logic [2:0]        size;
      logic [1:0]        burst;
      logic              lock;
      logic [3:0]        cache;
      logic [2:0]        prot;
      logic [3:0]        qos;
      logic [3:0]        region;
   } meta_t;

   // Ascending slot index so that slot 0 lands in the upper bits when packed.
   typedef logic [0:MAX_BEATS-1][DATA_W-1:0] data_slots_t;
   typedef logic [0:MAX_BEATS-1][STRB_W-1:0] strb_slots_t;

endpackage

// File: rtl/axi_packetizer_if.sv
// AXI4 write/read-address client port bundle (no R channel) for the packetizer.
// Latency: n/a (wires only).
// Backpressure: n/a; handshakes are carried by the member valid/ready pairs.
interface axi_packetizer_if;
   import memoredf_pkg::*;

   logic [ID_W-1:0]   S_AXI_AWID;
   logic [ADDR_W-1:0] S_AXI_AWADDR;
   logic [7:0]        S_AXI_AWLEN;
   logic [2:0]        S_AXI_AWSIZE;
   logic [1:0]        S_AXI_AWBURST;
   logic              S_AXI_AWLOCK;
   logic [3:0]        S_AXI_AWCACHE;
   logic [2:0]        S_AXI_AWPROT;
   logic [3:0]        S_AXI_AWQOS;
   logic [3:0]        S_AXI_AWREGION;
   logic              S_AXI_AWVALID;
   logic              S_AXI_AWREADY;

   logic [DATA_W-1:0] S_AXI_WDATA;
   logic [STRB_W-1:0] S_AXI_WSTRB;
   logic              S_AXI_WLAST;
   logic              S_AXI_WVALID;
   logic              S_AXI_WREADY;

   logic [ID_W-1:0]   S_AXI_BID;
   logic [1:0]        S_AXI_BRESP;
   logic              S_AXI_BVALID;
   logic              S_AXI_BREADY;

   logic [ID_W-1:0]   S_AXI_ARID;
   logic [ADDR_W-1:0] S_AXI_ARADDR;
   logic [7:0]        S_AXI_ARLEN;
   logic [2:0]        S_AXI_ARSIZE;
   logic [1:0]        S_AXI_ARBURST;
   logic              S_AXI_ARLOCK;
   logic [3:0]        S_AXI_ARCACHE;
   logic [2:0]        S_AXI_ARPROT;
   logic [3:0]        S_AXI_ARQOS;
   logic [3:0]        S_AXI_ARREGION;
   logic              S_AXI_ARVALID;
   logic              S_AXI_ARREADY;

   modport slave (
      input  S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST,
             S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS, S_AXI_AWREGION,
             S_AXI_AWVALID,
      output S_AXI_AWREADY,
      input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
      output S_AXI_WREADY,
      output S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
      input  S_AXI_BREADY,
      input  S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST,
             S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS, S_AXI_ARREGION,
             S_AXI_ARVALID,
      output S_AXI_ARREADY
   );

   modport master (
      output S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST,
             S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS, S_AXI_AWREGION,
             S_AXI_AWVALID,
      input  S_AXI_AWREADY,
      output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
      input  S_AXI_WREADY,
      input  S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
      output S_AXI_BREADY,
      output S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST,
             S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS, S_AXI_ARREGION,
             S_AXI_ARVALID,
      input  S_AXI_ARREADY
   );

endinterface

// File: rtl/axi_packetizer_arbiter.sv
// AR/AW grant selection; PACKETIZER_RR_EN selects round-robin, otherwise reads win.
// Latency: combinational grant; the last-grant register updates on the granted handshake.
// Backpressure: the losing request simply sees no grant and stays pending.
module packetizer_arbiter (
`ifdef PACKETIZER_RR_EN
   input  logic clk,
   input  logic rst_n,
   input  logic grant_en,
`endif
   input  logic req_r,
   input  logic req_w,
   output logic grant_r,
   output logic grant_w
);

`ifdef PACKETIZER_RR_EN
   logic last_w_q, last_w_d;

   // Contention goes to the channel that did not win last time.
   always_comb begin
      grant_w  = req_w & (~req_r | ~last_w_q);
      grant_r  = req_r & ~grant_w;
      last_w_d = last_w_q;
      if (grant_en && (grant_r || grant_w)) begin
         last_w_d = grant_w;
      end
   end

   // Remember which channel was granted most recently.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_w_q <= 1'b0;
      end else begin
         last_w_q <= last_w_d;
      end
   end
`else
   // Fixed priority: a pending read always beats a pending write.
   always_comb begin
      grant_r = req_r;
      grant_w = req_w & ~req_r;
   end
`endif

endmodule

// File: rtl/axi_packetizer.sv
// Packs one AXI read request or whole write burst (<=4 beats kept) into a flat scheduler packet.
// Latency: packet_valid one cycle after the AR or WLAST handshake; BVALID one cycle after packet accept.
// Backpressure: one transaction in flight; all readies stay low until packet_ready (and BREADY for writes).
// Build option: define PACKETIZER_RR_EN for round-robin AR/AW arbitration (default: reads first).
module axi_packetizer
   import memoredf_pkg::*;
(
   input  logic             S_AXI_ACLK,
   input  logic             S_AXI_ARESETN,
   axi_packetizer_if.slave  s_axi,
   output logic [PKT_W-1:0] packet_out,
   output logic             packet_valid,
   input  logic             packet_ready,
   output logic             overflow_error
);

   pkt_state_e  state_q, state_d;
   logic        type_q, type_d;
   meta_t       meta_q, meta_d;
   data_slots_t data_q, data_d;
   strb_slots_t strb_q, strb_d;
   logic [2:0]  beat_cnt_q, beat_cnt_d;
   logic        burst_ovf_q, burst_ovf_d;
   logic        overflow_error_q, overflow_error_d;

   logic        in_idle;
   logic        grant_r, grant_w;

   assign in_idle = (state_q == ST_IDLE);

   packetizer_arbiter u_arb (
`ifdef PACKETIZER_RR_EN
      .clk      (S_AXI_ACLK),
      .rst_n    (S_AXI_ARESETN),
      .grant_en (in_idle),
`endif
      .req_r    (s_axi.S_AXI_ARVALID),
      .req_w    (s_axi.S_AXI_AWVALID),
      .grant_r  (grant_r),
      .grant_w  (grant_w)
   );

   // Handshake outputs are pure decodes of the current state (and grant while idle).
   always_comb begin
      s_axi.S_AXI_ARREADY = in_idle & grant_r;
      s_axi.S_AXI_AWREADY = in_idle & grant_w;
      s_axi.S_AXI_WREADY  = (state_q == ST_WDATA);
      s_axi.S_AXI_BVALID  = (state_q == ST_BRESP);
      s_axi.S_AXI_BID     = meta_q.id;
      s_axi.S_AXI_BRESP   = ((state_q == ST_BRESP) && burst_ovf_q) ? RESP_SLVERR : RESP_OKAY;
      packet_valid        = (state_q == ST_PKT_OUT);
      overflow_error      = overflow_error_q;
   end

   // Packet is driven straight from the capture registers so it is stable while waiting.
   always_comb begin
      packet_out = '0;
      packet_out[TYPE_BIT]                     = type_q;
      packet_out[META_LSB +: META_W]           = meta_q;
      packet_out[STRB_LSB +: STRB_SLOTS_W]     = strb_q;
      packet_out[DATA_LSB +: DATA_SLOTS_W]     = data_q;
   end

   // Next-state and capture logic for the single in-flight transaction.
   always_comb begin
      state_d          = state_q;
      type_d           = type_q;
      meta_d           = meta_q;
      data_d           = data_q;
      strb_d           = strb_q;
      beat_cnt_d       = beat_cnt_q;
      burst_ovf_d      = burst_ovf_q;
      overflow_error_d = overflow_error_q;

      case (state_q)
         ST_IDLE: begin
            if (s_axi.S_AXI_ARREADY) begin
               type_d      = TYPE_READ;
               meta_d      = '{addr:   s_axi.S_AXI_ARADDR,  id:    s_axi.S_AXI_ARID,
                               len:    s_axi.S_AXI_ARLEN,   size:  s_axi.S_AXI_ARSIZE,
                               burst:  s_axi.S_AXI_ARBURST, lock:  s_axi.S_AXI_ARLOCK,
                               cache:  s_axi.S_AXI_ARCACHE, prot:  s_axi.S_AXI_ARPROT,
                               qos:    s_axi.S_AXI_ARQOS,   region: s_axi.S_AXI_ARREGION};
               data_d      = '0;
               strb_d      = '0;
               burst_ovf_d = 1'b0;
               state_d     = ST_PKT_OUT;
            end else if (s_axi.S_AXI_AWREADY) begin
               type_d      = TYPE_WRITE;
               meta_d      = '{addr:   s_axi.S_AXI_AWADDR,  id:    s_axi.S_AXI_AWID,
                               len:    s_axi.S_AXI_AWLEN,   size:  s_axi.S_AXI_AWSIZE,
                               burst:  s_axi.S_AXI_AWBURST, lock:  s_axi.S_AXI_AWLOCK,
                               cache:  s_axi.S_AXI_AWCACHE, prot:  s_axi.S_AXI_AWPROT,
                               qos:    s_axi.S_AXI_AWQOS,   region: s_axi.S_AXI_AWREGION};
               data_d      = '0;
               strb_d      = '0;
               beat_cnt_d  = '0;
               burst_ovf_d = 1'b0;
               state_d     = ST_WDATA;
            end
         end

         ST_WDATA: begin
            if (s_axi.S_AXI_WVALID) begin
               // beat_cnt saturates at 4; bit 2 set means every slot is already used.
               if (!beat_cnt_q[2]) begin
                  data_d[beat_cnt_q[1:0]] = s_axi.S_AXI_WDATA;
                  strb_d[beat_cnt_q[1:0]] = s_axi.S_AXI_WSTRB;
                  beat_cnt_d              = beat_cnt_q + 3'd1;
               end else begin
                  burst_ovf_d      = 1'b1;
                  overflow_error_d = 1'b1;
               end
               // WLAST, not AWLEN, closes the burst.
               if (s_axi.S_AXI_WLAST) begin
                  state_d = ST_PKT_OUT;
               end
            end
         end

         ST_PKT_OUT: begin
            if (packet_ready) begin
               state_d = (type_q == TYPE_WRITE) ? ST_BRESP : ST_IDLE;
            end
         end

         ST_BRESP: begin
            if (s_axi.S_AXI_BREADY) begin
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // State and capture registers; reset drops any partial packet immediately.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         state_q          <= ST_IDLE;
         type_q           <= 1'b0;
         meta_q           <= '0;
         data_q           <= '0;
         strb_q           <= '0;
         beat_cnt_q       <= '0;
         burst_ovf_q      <= 1'b0;
         overflow_error_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         type_q           <= type_d;
         meta_q           <= meta_d;
         data_q           <= data_d;
         strb_q           <= strb_d;
         beat_cnt_q       <= beat_cnt_d;
         burst_ovf_q      <= burst_ovf_d;
         overflow_error_q <= overflow_error_d;
      end
   end

endmodule

// File: tb/tb_axi_packetizer.sv
// Directed bench for axi_packetizer: reads, writes, overflow, arbitration and async reset.
// Inputs are driven on the falling edge, outputs sampled on the falling edge or shortly after.
// Build with PACKETIZER_RR_EN defined to exercise the round-robin arbitration order.
module tb_axi_packetizer;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [677:0] packet_out;
   logic         packet_valid;
   logic         packet_ready;
   logic         overflow_error;

   int checks = 0;
   int passes = 0;

   axi_packetizer_if axi ();

   axi_packetizer dut (
      .S_AXI_ACLK     (clk),
      .S_AXI_ARESETN  (rst_n),
      .s_axi          (axi),
      .packet_out     (packet_out),
      .packet_valid   (packet_valid),
      .packet_ready   (packet_ready),
      .overflow_error (overflow_error)
   );

   always #5 clk = ~clk;

   // Packet image built field by field from the documented layout, MSB first.
   function automatic logic [677:0] mk_pkt(input logic typ, input logic [39:0] addr,
         input logic [31:0] id, input logic [7:0] len, input logic [2:0] size,
         input logic [1:0] burst, input logic lock, input logic [3:0] cache,
         input logic [2:0] prot, input logic [3:0] qos, input logic [3:0] region,
         input logic [63:0] strb, input logic [511:0] data);
      return {typ, addr, id, len, size, burst, lock, cache, prot, qos, region, strb, data};
   endfunction

   function automatic logic [677:0] rd_pkt(input logic [39:0] addr, input logic [31:0] id,
                                           input logic [7:0] len);
      return mk_pkt(1'b0, addr, id, len, 3'd4, 2'b01, 1'b1, 4'hF, 3'h1, 4'hA, 4'h9, 64'h0, 512'h0);
   endfunction

   function automatic logic [677:0] wr_pkt(input logic [39:0] addr, input logic [31:0] id,
                                           input logic [7:0] len, input logic [63:0] strb,
                                           input logic [511:0] data);
      return mk_pkt(1'b1, addr, id, len, 3'd4, 2'b01, 1'b0, 4'h3, 3'h2, 4'h5, 4'h6, strb, data);
   endfunction

   // Issue an AR request; returns at the falling edge after the handshake edge.
   task automatic ar_req(input logic [39:0] addr, input logic [31:0] id, input logic [7:0] len,
                         output bit ok, output logic pv_before);
      axi.S_AXI_ARADDR = addr;  axi.S_AXI_ARID = id;      axi.S_AXI_ARLEN = len;
      axi.S_AXI_ARSIZE = 3'd4;  axi.S_AXI_ARBURST = 2'b01; axi.S_AXI_ARLOCK = 1'b1;
      axi.S_AXI_ARCACHE = 4'hF; axi.S_AXI_ARPROT = 3'h1;  axi.S_AXI_ARQOS = 4'hA;
      axi.S_AXI_ARREGION = 4'h9;
      axi.S_AXI_ARVALID = 1'b1;
      ok = 1'b0;
      pv_before = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         #1;
         if (axi.S_AXI_ARREADY) begin
            ok = 1'b1;
            pv_before = packet_valid;
         end
         @(negedge clk);
      end
      axi.S_AXI_ARVALID = 1'b0;
   endtask

   task automatic aw_set(input logic [39:0] addr, input logic [31:0] id, input logic [7:0] len);
      axi.S_AXI_AWADDR = addr;  axi.S_AXI_AWID = id;      axi.S_AXI_AWLEN = len;
      axi.S_AXI_AWSIZE = 3'd4;  axi.S_AXI_AWBURST = 2'b01; axi.S_AXI_AWLOCK = 1'b0;
      axi.S_AXI_AWCACHE = 4'h3; axi.S_AXI_AWPROT = 3'h2;  axi.S_AXI_AWQOS = 4'h5;
      axi.S_AXI_AWREGION = 4'h6;
   endtask

   task automatic aw_req(input logic [39:0] addr, input logic [31:0] id, input logic [7:0] len,
                         output bit ok);
      aw_set(addr, id, len);
      axi.S_AXI_AWVALID = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         #1;
         if (axi.S_AXI_AWREADY) ok = 1'b1;
         @(negedge clk);
      end
      axi.S_AXI_AWVALID = 1'b0;
   endtask

   task automatic w_beat(input logic [127:0] data, input logic [15:0] strb, input logic last,
                         output bit ok);
      axi.S_AXI_WDATA = data; axi.S_AXI_WSTRB = strb; axi.S_AXI_WLAST = last;
      axi.S_AXI_WVALID = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         #1;
         if (axi.S_AXI_WREADY) ok = 1'b1;
         @(negedge clk);
      end
      axi.S_AXI_WVALID = 1'b0;
      axi.S_AXI_WLAST  = 1'b0;
   endtask

   task automatic accept_pkt();
      packet_ready = 1'b1;
      @(negedge clk);
      packet_ready = 1'b0;
   endtask

   task automatic accept_b();
      axi.S_AXI_BREADY = 1'b1;
      @(negedge clk);
      axi.S_AXI_BREADY = 1'b0;
   endtask

   task automatic test_reset();
      axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_ARVALID = 1'b0; axi.S_AXI_WVALID = 1'b0;
      axi.S_AXI_WLAST = 1'b0;   axi.S_AXI_WDATA = '0;     axi.S_AXI_WSTRB = '0;
      axi.S_AXI_BREADY = 1'b0;  packet_ready = 1'b0;
      aw_set(40'h0, 32'h0, 8'h0);
      axi.S_AXI_ARADDR = '0; axi.S_AXI_ARID = '0; axi.S_AXI_ARLEN = '0; axi.S_AXI_ARSIZE = '0;
      axi.S_AXI_ARBURST = '0; axi.S_AXI_ARLOCK = '0; axi.S_AXI_ARCACHE = '0;
      axi.S_AXI_ARPROT = '0; axi.S_AXI_ARQOS = '0; axi.S_AXI_ARREGION = '0;
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++; if (axi.S_AXI_AWREADY !== 1'b0) $display("FAIL rst_awready got=%b exp=0", axi.S_AXI_AWREADY); else passes++;
      checks++; if (axi.S_AXI_WREADY !== 1'b0) $display("FAIL rst_wready got=%b exp=0", axi.S_AXI_WREADY); else passes++;
      checks++; if (axi.S_AXI_ARREADY !== 1'b0) $display("FAIL rst_arready got=%b exp=0", axi.S_AXI_ARREADY); else passes++;
      checks++; if (axi.S_AXI_BVALID !== 1'b0) $display("FAIL rst_bvalid got=%b exp=0", axi.S_AXI_BVALID); else passes++;
      checks++; if (packet_valid !== 1'b0) $display("FAIL rst_pvalid got=%b exp=0", packet_valid); else passes++;
      checks++; if (overflow_error !== 1'b0) $display("FAIL rst_ovf got=%b exp=0", overflow_error); else passes++;
      checks++; if (packet_out !== 678'h0) $display("FAIL rst_packet got=%h exp=0", packet_out); else passes++;
      checks++; if (axi.S_AXI_BID !== 32'h0) $display("FAIL rst_bid got=%h exp=0", axi.S_AXI_BID); else passes++;
      checks++; if (axi.S_AXI_BRESP !== 2'b00) $display("FAIL rst_bresp got=%b exp=00", axi.S_AXI_BRESP); else passes++;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_read();
      bit ok;
      logic pv_before;
      logic [677:0] exp;
      exp = rd_pkt(40'h40_0000_1000, 32'd5, 8'd0);
      ar_req(40'h40_0000_1000, 32'd5, 8'd0, ok, pv_before);
      checks++; if (!ok) $display("FAIL rd_ar_timeout got=no ARREADY exp=ARREADY"); else passes++;
      checks++; if (pv_before !== 1'b0) $display("FAIL rd_pv_early got=%b exp=0", pv_before); else passes++;
      checks++; if (packet_valid !== 1'b1) $display("FAIL rd_pv_latency got=%b exp=1", packet_valid); else passes++;
      checks++; if (packet_out !== exp) $display("FAIL rd_packet got=%h exp=%h", packet_out, exp); else passes++;
      checks++; if (packet_out[575:0] !== 576'h0) $display("FAIL rd_payload_zero got=%h exp=0", packet_out[575:0]); else passes++;
      checks++; if (packet_out[677] !== 1'b0) $display("FAIL rd_type got=%b exp=0", packet_out[677]); else passes++;
      accept_pkt();
      checks++; if (packet_valid !== 1'b0) $display("FAIL rd_pv_after got=%b exp=0", packet_valid); else passes++;
      checks++; if (axi.S_AXI_BVALID !== 1'b0) $display("FAIL rd_no_bvalid got=%b exp=0", axi.S_AXI_BVALID); else passes++;
   endtask

   task automatic test_write_full();
      bit ok;
      int to;
      logic [677:0] exp;
      exp = wr_pkt(40'h12_3456_7800, 32'hCAFE_0001, 8'd3, {4{16'hFFFF}},
                   {128'hA, 128'hB, 128'hC, 128'hD});
      // A beat offered while idle must not be taken.
      axi.S_AXI_WDATA = 128'hDEAD; axi.S_AXI_WSTRB = 16'h1; axi.S_AXI_WVALID = 1'b1;
      @(negedge clk);
      checks++; if (axi.S_AXI_WREADY !== 1'b0) $display("FAIL idle_wready_a got=%b exp=0", axi.S_AXI_WREADY); else passes++;
      @(negedge clk);
      checks++; if (axi.S_AXI_WREADY !== 1'b0) $display("FAIL idle_wready_b got=%b exp=0", axi.S_AXI_WREADY); else passes++;
      axi.S_AXI_WVALID = 1'b0;
      aw_req(40'h12_3456_7800, 32'hCAFE_0001, 8'd3, ok);
      checks++; if (!ok) $display("FAIL wr4_aw_timeout got=no AWREADY exp=AWREADY"); else passes++;
      to = 0;
      for (int i = 0; i < 4; i++) begin
         w_beat(128'hA + 128'(i), 16'hFFFF, (i == 3), ok);
         if (!ok) to++;
      end
      checks++; if (to != 0) $display("FAIL wr4_w_timeout got=%0d timeouts exp=0", to); else passes++;
      checks++; if (packet_valid !== 1'b1) $display("FAIL wr4_pv_latency got=%b exp=1", packet_valid); else passes++;
      checks++; if (packet_out !== exp) $display("FAIL wr4_packet got=%h exp=%h", packet_out, exp); else passes++;
      checks++; if (axi.S_AXI_BVALID !== 1'b0) $display("FAIL wr4_bvalid_early got=%b exp=0", axi.S_AXI_BVALID); else passes++;
      accept_pkt();
      checks++; if (axi.S_AXI_BVALID !== 1'b1) $display("FAIL wr4_bvalid got=%b exp=1", axi.S_AXI_BVALID); else passes++;
      checks++; if (axi.S_AXI_BID !== 32'hCAFE_0001) $display("FAIL wr4_bid got=%h exp=cafe0001", axi.S_AXI_BID); else passes++;
      checks++; if (axi.S_AXI_BRESP !== 2'b00) $display("FAIL wr4_bresp got=%b exp=00", axi.S_AXI_BRESP); else passes++;
      checks++; if (packet_valid !== 1'b0) $display("FAIL wr4_pv_drop got=%b exp=0", packet_valid); else passes++;
      accept_b();
      checks++; if (axi.S_AXI_BVALID !== 1'b0) $display("FAIL wr4_bvalid_drop got=%b exp=0", axi.S_AXI_BVALID); else passes++;
   endtask

   task automatic test_write_short();
      bit ok0, ok1, ok2;
      logic [677:0] exp;
      exp = wr_pkt(40'h00_0000_2000, 32'h0000_0077, 8'd1, {16'h00FF, 16'hF0F0, 32'h0},
                   {128'h11, 128'h22, 256'h0});
      aw_req(40'h00_0000_2000, 32'h0000_0077, 8'd1, ok0);
      w_beat(128'h11, 16'h00FF, 1'b0, ok1);
      w_beat(128'h22, 16'hF0F0, 1'b1, ok2);
      checks++; if (!(ok0 && ok1 && ok2)) $display("FAIL wr2_timeout got=%b%b%b exp=111", ok0, ok1, ok2); else passes++;
      checks++; if (axi.S_AXI_WREADY !== 1'b0) $display("FAIL wr2_wlast_ends got=%b exp=0", axi.S_AXI_WREADY); else passes++;
      checks++; if (packet_valid !== 1'b1) $display("FAIL wr2_pv got=%b exp=1", packet_valid); else passes++;
      checks++; if (packet_out !== exp) $display("FAIL wr2_packet got=%h exp=%h", packet_out, exp); else passes++;
      checks++; if (packet_out[255:0] !== 256'h0) $display("FAIL wr2_slot23_data got=%h exp=0", packet_out[255:0]); else passes++;
      accept_pkt();
      checks++; if (axi.S_AXI_BRESP !== 2'b00) $display("FAIL wr2_bresp got=%b exp=00", axi.S_AXI_BRESP); else passes++;
      accept_b();
   endtask

   task automatic test_overflow();
      bit ok;
      int to;
      logic pv_before;
      logic [677:0] exp;
      exp = wr_pkt(40'h01_0000_0100, 32'h0000_00AB, 8'd5, {4{16'hFFFF}},
                   {128'h1, 128'h2, 128'h3, 128'h4});
      checks++; if (overflow_error !== 1'b0) $display("FAIL ovf_pre got=%b exp=0", overflow_error); else passes++;
      aw_req(40'h01_0000_0100, 32'h0000_00AB, 8'd5, ok);
      to = ok ? 0 : 1;
      for (int i = 0; i < 6; i++) begin
         w_beat(128'h1 + 128'(i), 16'hFFFF, (i == 5), ok);
         if (!ok) to++;
      end
      checks++; if (to != 0) $display("FAIL ovf_timeout got=%0d timeouts exp=0", to); else passes++;
      checks++; if (packet_valid !== 1'b1) $display("FAIL ovf_pv got=%b exp=1", packet_valid); else passes++;
      checks++; if (packet_out !== exp) $display("FAIL ovf_packet got=%h exp=%h", packet_out, exp); else passes++;
      checks++; if (overflow_error !== 1'b1) $display("FAIL ovf_flag got=%b exp=1", overflow_error); else passes++;
      accept_pkt();
      checks++; if (axi.S_AXI_BRESP !== 2'b10) $display("FAIL ovf_bresp got=%b exp=10", axi.S_AXI_BRESP); else passes++;
      checks++; if (axi.S_AXI_BID !== 32'h0000_00AB) $display("FAIL ovf_bid got=%h exp=000000ab", axi.S_AXI_BID); else passes++;
      accept_b();
      // The flag is sticky across later clean transactions.
      ar_req(40'h00_0000_0300, 32'd3, 8'd0, ok, pv_before);
      checks++; if (packet_out !== rd_pkt(40'h00_0000_0300, 32'd3, 8'd0)) $display("FAIL ovf_next_rd got=%h", packet_out); else passes++;
      accept_pkt();
      checks++; if (overflow_error !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", overflow_error); else passes++;
   endtask

   task automatic test_arbitration();
      bit exp_w [4];
      int pend_r;
      int pend_w;
`ifdef PACKETIZER_RR_EN
      exp_w = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
      exp_w = '{1'b0, 1'b0, 1'b1, 1'b1};
`endif
      // Fresh reset so the last-grant register starts from a known value.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      pend_r = 2;
      pend_w = 2;
      axi.S_AXI_ARADDR = 40'h00_0000_5000; axi.S_AXI_ARID = 32'd21; axi.S_AXI_ARLEN = 8'd0;
      axi.S_AXI_ARSIZE = 3'd4; axi.S_AXI_ARBURST = 2'b01; axi.S_AXI_ARLOCK = 1'b1;
      axi.S_AXI_ARCACHE = 4'hF; axi.S_AXI_ARPROT = 3'h1; axi.S_AXI_ARQOS = 4'hA;
      axi.S_AXI_ARREGION = 4'h9;
      aw_set(40'h00_0000_6000, 32'd22, 8'd0);
      for (int k = 0; k < 4; k++) begin
         bit ok;
         bit got_w;
         bit both;
         bit bok;
         ok = 1'b0; got_w = 1'b0; both = 1'b0;
         axi.S_AXI_ARVALID = (pend_r > 0);
         axi.S_AXI_AWVALID = (pend_w > 0);
         for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (axi.S_AXI_ARREADY || axi.S_AXI_AWREADY) begin
               ok    = 1'b1;
               got_w = axi.S_AXI_AWREADY;
               both  = axi.S_AXI_ARREADY && axi.S_AXI_AWREADY;
            end
            @(negedge clk);
         end
         if (got_w) pend_w--; else pend_r--;
         axi.S_AXI_ARVALID = (pend_r > 0);
         axi.S_AXI_AWVALID = (pend_w > 0);
         checks++; if (!ok) $display("FAIL arb%0d_timeout got=no grant exp=grant", k); else passes++;
         checks++; if (got_w !== exp_w[k]) $display("FAIL arb%0d_order got_w=%b exp_w=%b", k, got_w, exp_w[k]); else passes++;
         checks++; if (both !== 1'b0) $display("FAIL arb%0d_both_ready got=%b exp=0", k, both); else passes++;
         if (got_w) begin
            w_beat(128'h55, 16'hFFFF, 1'b1, bok);
            checks++; if (packet_out[677] !== 1'b1) $display("FAIL arb%0d_wtype got=%b exp=1", k, packet_out[677]); else passes++;
            accept_pkt();
            accept_b();
         end else begin
            checks++; if (packet_out[677] !== 1'b0) $display("FAIL arb%0d_rtype got=%b exp=0", k, packet_out[677]); else passes++;
            accept_pkt();
         end
      end
      axi.S_AXI_ARVALID = 1'b0;
      axi.S_AXI_AWVALID = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit ok;
      logic pv_before;
      int held;
      logic [677:0] exp;
      exp = rd_pkt(40'h7F_FFFF_FFC0, 32'hFFFF_FFFF, 8'hFF);
      ar_req(40'h7F_FFFF_FFC0, 32'hFFFF_FFFF, 8'hFF, ok, pv_before);
      held = 0;
      for (int i = 0; i < 10; i++) begin
         if (packet_valid === 1'b1 && packet_out === exp) held++;
         @(negedge clk);
      end
      checks++; if (held != 10) $display("FAIL mid_hold got=%0d stable cycles exp=10", held); else passes++;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (packet_valid !== 1'b0) $display("FAIL mid_pv_async got=%b exp=0", packet_valid); else passes++;
      checks++; if (packet_out !== 678'h0) $display("FAIL mid_packet got=%h exp=0", packet_out); else passes++;
      checks++; if (axi.S_AXI_BID !== 32'h0) $display("FAIL mid_bid got=%h exp=0", axi.S_AXI_BID); else passes++;
      checks++; if (axi.S_AXI_WREADY !== 1'b0 || axi.S_AXI_BVALID !== 1'b0 || overflow_error !== 1'b0)
         $display("FAIL mid_ctrl got=w%b b%b o%b exp=000", axi.S_AXI_WREADY, axi.S_AXI_BVALID, overflow_error);
      else passes++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      exp = rd_pkt(40'h00_0000_0040, 32'd9, 8'd0);
      ar_req(40'h00_0000_0040, 32'd9, 8'd0, ok, pv_before);
      checks++; if (!ok) $display("FAIL post_ar_timeout got=no ARREADY exp=ARREADY"); else passes++;
      checks++; if (packet_valid !== 1'b1) $display("FAIL post_pv got=%b exp=1", packet_valid); else passes++;
      checks++; if (packet_out !== exp) $display("FAIL post_packet got=%h exp=%h", packet_out, exp); else passes++;
      accept_pkt();
      checks++; if (packet_valid !== 1'b0) $display("FAIL post_pv_drop got=%b exp=0", packet_valid); else passes++;
   endtask

   initial begin
      test_reset();
      test_read();
      test_write_full();
      test_write_short();
      test_overflow();
      test_arbitration();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish (%0d/%0d so far)", passes, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
